ram_req_ctrl: RTL and testbench

Request front-end sitting directly upstream of the dual-read/single-write RAM (8-bit address, 32-bit data). It accepts a valid/ready command stream of reads and writes, drives the RAM write port and read port A, and returns read data on a valid/ready response stream through a small response FIFO. After every reset it sweeps the whole RAM to a known value before accepting commands, and it forwards in-flight write data so a read immediately following a write to the same address returns the new value.

---
 rtl/ram_req_pkg.sv | 14 +
 rtl/ram_rsp_fifo.sv | 52 +++++
 rtl/ram_req_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_req_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_req_pkg.sv
// Shared defaults and state encoding for the RAM request front-end.
package ram_req_pkg;

    localparam int unsigned AW_DEFAULT        = 8;
    localparam int unsigned DW_DEFAULT        = 32;
    localparam int unsigned RSP_DEPTH_DEFAULT = 2;
    localparam logic [31:0] INIT_VALUE_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        INIT,
        RUN
    } ctrl_state_e;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small synchronous response FIFO; extra pointer bit separates full from empty.
module ram_rsp_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is cleared on reset so the read-data output is zero until the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Command front-end for the dual-read/single-write RAM: post-reset sweep,
// registered write port, read port A with write forwarding, response FIFO.
module ram_req_ctrl
    import ram_req_pkg::*;
#(
    parameter int unsigned   AW         = AW_DEFAULT,
    parameter int unsigned   DW         = DW_DEFAULT,
    parameter logic [DW-1:0] INIT_VALUE = DW'(INIT_VALUE_DEFAULT),
    parameter int unsigned   RSP_DEPTH  = RSP_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_addr_a,
    input  logic [DW-1:0] ram_data_a,
    output logic [AW-1:0] ram_addr_wr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we
);

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    ctrl_state_e   state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [DW-1:0] fifo_push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // The write-port registers double as the pending-write record used for forwarding:
    // the RAM only commits them one edge later, so a read in between must see them here.
    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        cmd_ready      = 1'b0;
        fifo_push      = 1'b0;
        fifo_push_data = ram_data_a;

        case (state_q)
            INIT: begin
                we_d    = 1'b1;
                waddr_d = sweep_q;
                wdata_d = INIT_VALUE;
                if (sweep_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    sweep_d = sweep_q + ADDR_ONE;
                end
            end
            RUN: begin
                cmd_ready = !fifo_full;
                if (cmd_valid && !fifo_full) begin
                    if (cmd_we) begin
                        we_d    = 1'b1;
                        waddr_d = cmd_addr;
                        wdata_d = cmd_wdata;
                    end else begin
                        fifo_push = 1'b1;
                        if (we_q && (waddr_q == cmd_addr)) begin
                            fifo_push_data = wdata_q;
                        end
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign fifo_pop    = rsp_valid && rsp_ready;
    assign rsp_valid   = !fifo_empty;
    assign init_done   = (state_q == RUN);
    assign ram_addr_a  = cmd_addr;
    assign ram_we      = we_q;
    assign ram_addr_wr = waddr_q;
    assign ram_data_in = wdata_q;

    ram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .data_o      (rsp_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: behavioural RAM, command table, response scoreboard
// and hand-written back-pressure / mid-stream reset sequences.
module tb_ram_req_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [DW-1:0] INIT_WORD = 32'h0000_0000;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expData;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_a;
    logic [AW-1:0] ram_addr_wr;
    logic [DW-1:0] ram_data_in;
    logic          ram_we;

    int            compared = 0;
    int            mismatched = 0;
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] ramModel [2**AW];
    vec_t          vecs [$];

    always #5 clk = ~clk;

    ram_req_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_addr_wr (ram_addr_wr),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we)
    );

    // RAM starts with garbage so only a real sweep produces INIT_WORD on read-back.
    assign ram_data_a = ramModel[ram_addr_a];
    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ramModel[i] = 32'hBAD0_0000 + 32'(i);
        end
        forever begin
            @(posedge clk);
            if (ram_we) ramModel[ram_addr_wr] <= ram_data_in;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // A handshake is decided by values held stable from just after one edge to the next,
    // so the negedge view predicts exactly what the following posedge does.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected response: got 0x%08h, expected none", rsp_rdata);
            end else begin
                checkOutput("rsp_rdata", rsp_rdata, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expData);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) reportTimeout("cmd accept");
        else if (!we) expQ.push_back(expData);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " cmd_ready"},   32'(cmd_ready),   32'd0);
        checkOutput({tag, " rsp_valid"},   32'(rsp_valid),   32'd0);
        checkOutput({tag, " rsp_rdata"},   rsp_rdata,        32'd0);
        checkOutput({tag, " init_done"},   32'(init_done),   32'd0);
        checkOutput({tag, " ram_we"},      32'(ram_we),      32'd0);
        checkOutput({tag, " ram_addr_wr"}, 32'(ram_addr_wr), 32'd0);
        checkOutput({tag, " ram_data_in"}, ram_data_in,      32'd0);
    endtask

    // Called just after reset release; counts cycles with cmd_ready low.
    task automatic waitSweep(input string tag);
        int lowCycles = 0;
        @(negedge clk);
        while (!cmd_ready && lowCycles < 1000) begin
            if (lowCycles == 1) begin
                checkOutput({tag, " first sweep we"},   32'(ram_we),      32'd1);
                checkOutput({tag, " first sweep addr"}, 32'(ram_addr_wr), 32'd0);
                checkOutput({tag, " first sweep data"}, ram_data_in,      INIT_WORD);
                checkOutput({tag, " init_done mid"},    32'(init_done),   32'd0);
            end
            if (lowCycles == 2) checkOutput({tag, " second sweep addr"}, 32'(ram_addr_wr), 32'd1);
            lowCycles++;
            @(negedge clk);
        end
        checkOutput({tag, " cmd_ready low cycles"}, 32'(lowCycles), 32'd256);
        checkOutput({tag, " init_done"},            32'(init_done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drainQueue(input string tag);
        int waited = 0;
        while ((expQ.size() != 0 || rsp_valid) && waited < 50) begin
            waited++;
            @(posedge clk);
            #1;
        end
        if (expQ.size() != 0 || rsp_valid) reportTimeout({tag, " drain"});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back('{1'b0, 8'd0,   32'h0,         INIT_WORD});
        vecs.push_back('{1'b0, 8'd1,   32'h0,         INIT_WORD});
        vecs.push_back('{1'b0, 8'd255, 32'h0,         INIT_WORD});
        vecs.push_back('{1'b1, 8'd1,   32'hA5A5_A5A5, 32'h0});
        vecs.push_back('{1'b0, 8'd1,   32'h0,         32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 8'd0,   32'h0,         INIT_WORD});
        vecs.push_back('{1'b1, 8'd0,   32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b1, 8'd0,   32'h1234_5678, 32'h0});
        vecs.push_back('{1'b0, 8'd0,   32'h0,         32'h1234_5678});
        vecs.push_back('{1'b0, 8'd1,   32'h0,         32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 8'd0,   32'h0,         32'h1234_5678});
        vecs.push_back('{1'b1, 8'd200, 32'h0F0F_0F0F, 32'h0});
        vecs.push_back('{1'b0, 8'd201, 32'h0,         INIT_WORD});
        vecs.push_back('{1'b0, 8'd200, 32'h0,         32'h0F0F_0F0F});

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        waitSweep("sweep1");

        rsp_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expData);
        end
        drainQueue("table");

        // Back-pressure: two reads fill the FIFO, the third stalls until a pop has landed.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'd1, 32'h0, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 8'd0, 32'h0, 32'h1234_5678);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 8'd255;
        @(negedge clk);
        checkOutput("full cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("full rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("full head data", rsp_rdata, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("full+pop cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("after pop cmd_ready", 32'(cmd_ready), 32'd1);
        if (cmd_ready) expQ.push_back(INIT_WORD);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drainQueue("backpressure");

        // Mid-stream reset with a queued response and a pending write.
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 8'd7, 32'hCAFE_F00D, 32'h0);
        applyStimulus(1'b0, 8'd3, 32'h0, INIT_WORD);
        applyStimulus(1'b1, 8'd8, 32'h0BAD_F00D, 32'h0);
        checkOutput("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("pre-reset ram_we",    32'(ram_we),    32'd1);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkResetState("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitSweep("sweep2");
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 8'd7, 32'h0, INIT_WORD);
        applyStimulus(1'b0, 8'd8, 32'h0, INIT_WORD);
        applyStimulus(1'b0, 8'd3, 32'h0, INIT_WORD);
        drainQueue("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
